ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port 256x8 synchronous RAM.
- Port 0 is the CPU memory stage. Port 1 is the program loader / debug port.
- Serialises requests, drives the RAM address, read-enable and write-enable, captures read data and returns a one-cycle ack to the granted requester.
- Sits between the CPU core and the RAM at the top level.

Parameters:
- ADDR_W, 8, address width (RAM depth 2^ADDR_W).
- DATA_W, 8, data width.
- FIXED_PRI, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 request, level, held until ack.
- m0_we  in  1  port 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_ack  out  1  port 0 completion pulse.
- m0_rdata  out  DATA_W  port 0 read data, registered.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1.
- ram_addr  out  ADDR_W  RAM address.
- ram_rEN  out  1  RAM read enable.
- ram_wEN  out  1  RAM write enable.
- ram_wdata  out  DATA_W  data driven toward RAM on write.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_rEN.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - All acks, ram_rEN, ram_wEN and busy = 0.
  - ram_addr, ram_wdata, m0_rdata, m1_rdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
- Reset mid-transaction aborts it: no ack is issued and no RAM enable is asserted in the following cycle.
- FSM states:
  - IDLE: sample requests. If any request is active, grant and go to WR (we=1) or RD (we=0). Otherwise stay in IDLE.
  - WR: ram_wEN=1 for exactly one cycle, then go to DONE.
  - RD: ram_rEN=1 for exactly one cycle, then go to RD_DATA.
  - RD_DATA: at the end of this cycle, ram_rdata is loaded into the granted port's rdata register. Go to DONE.
  - DONE: the granted port's ack=1 for one cycle. Go to IDLE.
- Grant (at the IDLE edge):
  - The winner's addr, we and wdata are latched into ram_addr and ram_wdata registers.
  - Requester changes after the grant are ignored until the ack.
- Arbitration:
  - Only one request active: it wins.
  - Both active, FIXED_PRI=0: the port not equal to last_grant wins.
  - Both active, FIXED_PRI=1: port 0 wins.
  - last_grant updates on every grant.
- Latency, counted from the IDLE cycle in which the request is sampled:
  - Write: ack 2 cycles later.
  - Read: ack 3 cycles later.
  - Back-to-back throughput: 3 cycles per write, 4 cycles per read.
- Requester protocol:
  - Hold req, addr, we and wdata stable until the ack.
  - In the cycle after the ack, either drop req or present a new transaction.
  - If req drops before the ack, the transaction still completes and the ack still pulses.
- Invariants:
  - ram_rEN and ram_wEN are never both 1.
  - Both enables are 0 in IDLE, RD_DATA and DONE.
  - At most one ack is high per cycle.
- rdata per port: holds its value until that port's next read completes. It is unchanged by writes and by the other port's reads.
- busy=1 in WR, RD, RD_DATA and DONE.
- Addresses use full ADDR_W with no wrap logic: 0xFF is a legal address.

Test Plan:
- Port 0 write addr 0x10, data 0xA5, then read addr 0x10 → ram_wEN pulses one cycle with ram_addr=0x10; write ack 2 cycles after sampling; read ack 3 cycles after sampling with m0_rdata=0xA5.
- m0 and m1 reads asserted in the same cycle, FIXED_PRI=0, after reset → m0 granted first, then m1; then a second simultaneous pair → m1 granted first (alternation).
- FIXED_PRI=1, both ports continuously requesting → m0 serviced every transaction; m1 acks only once m0_req drops.
- Port 1 write 0x3C to 0xFF while port 0 reads 0x00 (contents 0x77) → port 1 completes without changing m0_rdata; m0_rdata=0x77; ram_rEN and ram_wEN never overlap.
- rst asserted in the RD_DATA cycle of a port 0 read → no m0_ack, m0_rdata=0x00, state IDLE, busy=0 on the next cycle.
- During a read, m0_addr changes from 0x20 to 0x21 after the grant → ram_addr stays 0x20; rdata equals the contents of 0x20.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous RAM.
// One transaction at a time: grant in IDLE, one enable cycle, optional data capture, one-cycle ack.
module ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rEN,
  output logic              ram_wEN,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_DATA, DONE} state_t;

  state_t            state_reg, state_next;
  logic              grant_reg;
  logic              last_grant_reg;
  logic              winner;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg [2];
  logic [1:0]        req;
  logic [1:0]        we_in;
  logic [ADDR_W-1:0] addr_in  [2];
  logic [DATA_W-1:0] wdata_in [2];

  assign req         = {m1_req, m0_req};
  assign we_in       = {m1_we, m0_we};
  assign addr_in[0]  = m0_addr;
  assign addr_in[1]  = m1_addr;
  assign wdata_in[0] = m0_wdata;
  assign wdata_in[1] = m1_wdata;

  // On a tie, round-robin favours the port that was not granted last.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = (FIXED_PRI != 0) ? 1'b0 : ~last_grant_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    ram_rEN    = 1'b0;
    ram_wEN    = 1'b0;
    busy       = 1'b1;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (|req) begin
          state_next = we_in[winner] ? WR : RD;
        end
      end
      WR: begin
        ram_wEN    = 1'b1;
        state_next = DONE;
      end
      RD: begin
        ram_rEN    = 1'b1;
        state_next = RD_DATA;
      end
      RD_DATA: state_next = DONE;
      DONE: begin
        m0_ack     = ~grant_reg;
        m1_ack     = grant_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && (|req)) begin
        grant_reg      <= winner;
        last_grant_reg <= winner;
        addr_reg       <= addr_in[winner];
        wdata_reg      <= wdata_in[winner];
      end
    end
  end

  // Each port's read register only changes when its own read reaches RD_DATA.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_reg[gi] <= '0;
      end else if (state_reg == RD_DATA && grant_reg == 1'(gi)) begin
        rdata_reg[gi] <= ram_rdata;
      end
    end
  end

  assign ram_addr  = addr_reg;
  assign ram_wdata = wdata_reg;
  assign m0_rdata  = rdata_reg[0];
  assign m1_rdata  = rdata_reg[1];

endmodule
